// File: rtl/vec_csr_regfile_pkg.sv
// Shared types and constants for the vector configuration CSR block.
// Covers element-width/LMUL encodings, the FSM state type and the vill reset value.
package vec_csr_regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int VLEN_DEF = 512;
   localparam int ELEN_DEF = 32;

   typedef enum logic [2:0] {
      E8  = 3'b000,
      E16 = 3'b001,
      E32 = 3'b010,
      E64 = 3'b011
   } vsew_e;

   typedef enum logic [2:0] {
      M1  = 3'b000,
      M2  = 3'b001,
      M4  = 3'b010,
      M8  = 3'b011,
      MF8 = 3'b101,
      MF4 = 3'b110,
      MF2 = 3'b111
   } vlmul_e;

   localparam logic [2:0] VLMUL_RSVD = 3'b100;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } csr_state_e;

   localparam logic [XLEN_DEF-1:0] VTYPE_VILL_RESET = {1'b1, {(XLEN_DEF-1){1'b0}}};

   function automatic logic lmul_is_frac(input logic [2:0] vlmul);
      return vlmul[2] && (vlmul[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational VLMAX and vtype legality from (vsew, vlmul), shifts only.
// Also used by the decode-side comparator, so keep it free of state.
module vec_vlmax_calc
   import vec_csr_regfile_pkg::*;
#(
   parameter int VLEN = VLEN_DEF,
   parameter int ELEN = ELEN_DEF,
   parameter int VLW  = $clog2(VLEN) + 1
) (
   input  logic [2:0]     vsew,
   input  logic [2:0]     vlmul,
   output logic [VLW-1:0] vlmax,
   output logic           vtype_illegal
);

   logic [31:0]    sew_bits;
   logic [31:0]    sew_scaled;
   logic [3:0]     frac_sh;
   logic [VLW-1:0] base;

   always_comb begin
      sew_bits   = 32'd8 << vsew;
      frac_sh    = 4'd8 - {1'b0, vlmul};
      // SEW > ELEN*LMUL for fractional LMUL, rewritten as SEW << (8-vlmul) > ELEN
      sew_scaled = sew_bits << frac_sh;
      base       = VLW'(VLEN) >> ({1'b0, vsew} + 4'd3);

      vtype_illegal = vsew[2]
                   || (sew_bits > 32'(ELEN))
                   || (vlmul == VLMUL_RSVD)
                   || (lmul_is_frac(vlmul) && (sew_scaled > 32'(ELEN)));

      vlmax = '0;
      if (!vtype_illegal) begin
         if (vlmul[2])
            vlmax = base >> frac_sh;
         else
            vlmax = base << vlmul[1:0];
      end
   end

endmodule

// File: rtl/vec_csr_regfile.sv
// Vector configuration CSRs (vl, vtype, vstart) with a vsetvl response handshake.
// state | meaning
// IDLE  | ready for a config write; CSRs latch on cfg_valid
// RESP  | new vl presented on rd_data until rd_ready
module vec_csr_regfile
   import vec_csr_regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int VLEN = VLEN_DEF,
   parameter int ELEN = ELEN_DEF,
   parameter int VLW  = $clog2(VLEN) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [XLEN-1:0] scalar1,
   input  logic [XLEN-1:0] scalar2,
   output logic            rd_valid,
   input  logic            rd_ready,
   output logic [XLEN-1:0] rd_data,
   input  logic            vstart_wr_en,
   input  logic [VLW-1:0]  vstart_wdata,
   output logic [VLW-1:0]  csr_vl,
   output logic [XLEN-1:0] csr_vtype,
   output logic [VLW-1:0]  csr_vstart,
   output logic [2:0]      csr_sew,
   output logic [2:0]      csr_lmul,
   output logic [VLW-1:0]  csr_vlmax,
   output logic            csr_vill
);

   localparam logic [XLEN-1:0] VILL_VTYPE = XLEN'(VTYPE_VILL_RESET) << (XLEN - XLEN_DEF);

   csr_state_e     state, next_state;
   logic           accept;
   logic [VLW-1:0] calc_vlmax;
   logic           calc_illegal;
   logic           req_legal;
   logic [VLW-1:0] new_vl;

   vec_vlmax_calc #(
      .VLEN (VLEN),
      .ELEN (ELEN),
      .VLW  (VLW)
   ) u_vlmax_calc (
      .vsew          (scalar2[5:3]),
      .vlmul         (scalar2[2:0]),
      .vlmax         (calc_vlmax),
      .vtype_illegal (calc_illegal)
   );

   assign req_legal = !calc_illegal && (scalar2[XLEN-1:8] == '0);
   // full-width AVL compare so large AVLs never alias to small vl values
   assign new_vl    = (scalar1 > XLEN'(calc_vlmax)) ? calc_vlmax : scalar1[VLW-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      rd_valid   = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               accept     = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            rd_valid = 1'b1;
            if (rd_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csr_vl    <= '0;
         csr_vtype <= VILL_VTYPE;
         csr_sew   <= '0;
         csr_lmul  <= '0;
         csr_vlmax <= '0;
         rd_data   <= '0;
      end else if (accept) begin
         if (req_legal) begin
            csr_vl    <= new_vl;
            csr_vtype <= scalar2;
            csr_sew   <= scalar2[5:3];
            csr_lmul  <= scalar2[2:0];
            csr_vlmax <= calc_vlmax;
            rd_data   <= XLEN'(new_vl);
         end else begin
            csr_vl    <= '0;
            csr_vtype <= VILL_VTYPE;
            csr_sew   <= '0;
            csr_lmul  <= '0;
            csr_vlmax <= '0;
            rd_data   <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         csr_vstart <= '0;
      else if (accept)
         csr_vstart <= '0;
      else if (vstart_wr_en)
         csr_vstart <= vstart_wdata;
   end

   assign csr_vill = csr_vtype[XLEN-1];

endmodule
